sreg_thr_monitor: RTL and testbench

Threshold monitor that sits downstream of the `sreg` register bank. It consumes the `i1Thresholds` low threshold (stored field) and the high threshold (wire field, written through on a strobe). It latches the high threshold locally and returns it for read-back on `i1Thresholds_i[31:16]`. A stream of 16-bit samples is compared against both thresholds with hysteresis and debounce, producing a debounced alarm, a configuration-error flag and an optional alarm-event counter.

---
 rtl/sreg_thr_monitor.sv | 143 ++++++++++++++
 tb/tb_sreg_thr_monitor.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sreg_thr_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sreg_thr_monitor                                                         |
// | Sample threshold monitor: latched high threshold with read-back, strict  |
// | hysteresis compare with debounce, config-error flag, optional saturating |
// | alarm-event counter (enabled by defining THR_MON_EVCNT_EN).              |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module sreg_thr_monitor #(
  parameter int DEBOUNCE = 4,
  parameter int COUNT_W  = 8
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [15:0]        sample_i,
  input  logic               sample_valid_i,
  input  logic [15:0]        thr_low_i,
  input  logic [15:0]        thr_high_i,
  input  logic               thr_high_wr_i,
  input  logic               evcnt_clr_i,
  output logic [15:0]        thr_high_rb_o,
  output logic               alarm_o,
  output logic               cfg_err_o,
  output logic [COUNT_W-1:0] evcnt_o
);

  typedef enum logic [1:0] {
    ST_NORMAL  = 2'd0,
    ST_PEND_HI = 2'd1,
    ST_ALARM   = 2'd2,
    ST_PEND_LO = 2'd3
  } state_e;

  localparam logic [7:0] C_DEBOUNCE = 8'(DEBOUNCE);

  state_e      state_q, state_d;
  logic [7:0]  dcnt_q, dcnt_d;
  logic [15:0] thr_high_q, thr_high_d;
  logic        cfg_err_q, cfg_err_d;
  logic        alarm_q, alarm_d;
  logic        w_hi, w_lo, w_rise;

  always_comb begin
    thr_high_d = thr_high_wr_i ? thr_high_i : thr_high_q;
    // Compare against the currently latched value: a same-cycle write takes effect next cycle.
    cfg_err_d  = (thr_low_i > thr_high_q);
    w_hi       = (sample_i > thr_high_q);
    w_lo       = (sample_i < thr_low_i);
    state_d    = state_q;
    dcnt_d     = dcnt_q;

    if (cfg_err_d || cfg_err_q) begin
      state_d = ST_NORMAL;
      dcnt_d  = 8'd0;
    end else if (sample_valid_i) begin
      case (state_q)
        ST_NORMAL: begin
          if (w_hi) begin
            dcnt_d  = 8'd1;
            state_d = (C_DEBOUNCE == 8'd1) ? ST_ALARM : ST_PEND_HI;
          end
        end
        ST_PEND_HI: begin
          if (w_hi) begin
            dcnt_d = dcnt_q + 8'd1;
            if (dcnt_q + 8'd1 == C_DEBOUNCE) state_d = ST_ALARM;
          end else begin
            dcnt_d  = 8'd0;
            state_d = ST_NORMAL;
          end
        end
        ST_ALARM: begin
          if (w_lo) begin
            dcnt_d  = 8'd1;
            state_d = (C_DEBOUNCE == 8'd1) ? ST_NORMAL : ST_PEND_LO;
          end
        end
        ST_PEND_LO: begin
          if (w_lo) begin
            dcnt_d = dcnt_q + 8'd1;
            if (dcnt_q + 8'd1 == C_DEBOUNCE) state_d = ST_NORMAL;
          end else begin
            dcnt_d  = 8'd0;
            state_d = ST_ALARM;
          end
        end
        default: begin
          state_d = ST_NORMAL;
          dcnt_d  = 8'd0;
        end
      endcase
    end

    alarm_d = (state_d == ST_ALARM) || (state_d == ST_PEND_LO);
    w_rise  = (state_d == ST_ALARM) &&
              ((state_q == ST_NORMAL) || (state_q == ST_PEND_HI));
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_NORMAL;
      dcnt_q     <= 8'd0;
      thr_high_q <= 16'hFFFF;
      cfg_err_q  <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      dcnt_q     <= dcnt_d;
      thr_high_q <= thr_high_d;
      cfg_err_q  <= cfg_err_d;
      alarm_q    <= alarm_d;
    end
  end

  assign thr_high_rb_o = thr_high_q;
  assign alarm_o       = alarm_q;
  assign cfg_err_o     = cfg_err_q;

`ifdef THR_MON_EVCNT_EN
  logic [COUNT_W-1:0] evcnt_q, evcnt_d;

  always_comb begin
    evcnt_d = evcnt_q;
    if (evcnt_clr_i)
      evcnt_d = '0;
    else if (w_rise && (evcnt_q != '1))
      evcnt_d = evcnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) evcnt_q <= '0;
    else          evcnt_q <= evcnt_d;
  end

  assign evcnt_o = evcnt_q;
`else
  logic w_evcnt_unused;
  assign w_evcnt_unused = evcnt_clr_i | w_rise;
  assign evcnt_o        = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sreg_thr_monitor.sv
`default_nettype none
// Bench for sreg_thr_monitor: two instances (DEBOUNCE=4/COUNT_W=2 and
// DEBOUNCE=1/COUNT_W=8) against a run-length behavioural model.
module tb_sreg_thr_monitor;

  localparam int D0 = 4, CW0 = 2, D1 = 1, CW1 = 8;
  localparam int DCFG [2] = '{D0, D1};
  localparam int EVMAX[2] = '{3, 255};
`ifdef THR_MON_EVCNT_EN
  localparam bit EV_EN = 1'b1;
`else
  localparam bit EV_EN = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b1;
  logic [15:0] sample = '0, thr_low = '0, thr_high = '0;
  logic valid = 1'b0, wr = 1'b0, clr = 1'b0;

  logic [15:0] rb0, rb1;
  logic alarm0, alarm1, cfg0, cfg1;
  logic [CW0-1:0] ev0;
  logic [CW1-1:0] ev1;

  int n_checks = 0, n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  sreg_thr_monitor #(.DEBOUNCE(D0), .COUNT_W(CW0)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .sample_i(sample), .sample_valid_i(valid),
    .thr_low_i(thr_low), .thr_high_i(thr_high), .thr_high_wr_i(wr),
    .evcnt_clr_i(clr), .thr_high_rb_o(rb0), .alarm_o(alarm0),
    .cfg_err_o(cfg0), .evcnt_o(ev0)
  );

  sreg_thr_monitor #(.DEBOUNCE(D1), .COUNT_W(CW1)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .sample_i(sample), .sample_valid_i(valid),
    .thr_low_i(thr_low), .thr_high_i(thr_high), .thr_high_wr_i(wr),
    .evcnt_clr_i(clr), .thr_high_rb_o(rb1), .alarm_o(alarm1),
    .cfg_err_o(cfg1), .evcnt_o(ev1)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: alarm flag plus the length of the current run of valid samples
  // pointing towards the opposite alarm state.
  logic [15:0] m_thr;
  bit m_cfg, m_bad, m_toward, m_rise;
  bit m_alarm[2];
  int m_run[2], m_ev[2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_thr = 16'hFFFF;
      m_cfg = 1'b0;
      for (int k = 0; k < 2; k++) begin
        m_alarm[k] = 1'b0; m_run[k] = 0; m_ev[k] = 0;
      end
    end else begin
      m_bad = (thr_low > m_thr);
      for (int k = 0; k < 2; k++) begin
        m_rise = 1'b0;
        if (m_bad || m_cfg) begin
          m_alarm[k] = 1'b0; m_run[k] = 0;
        end else if (valid) begin
          m_toward = m_alarm[k] ? (sample < thr_low) : (sample > m_thr);
          if (m_toward) begin
            m_run[k]++;
            if (m_run[k] == DCFG[k]) begin
              m_rise     = !m_alarm[k];
              m_alarm[k] = !m_alarm[k];
              m_run[k]   = 0;
            end
          end else begin
            m_run[k] = 0;
          end
        end
        if (EV_EN) begin
          if (clr) m_ev[k] = 0;
          else if (m_rise && m_ev[k] < EVMAX[k]) m_ev[k]++;
        end
      end
      m_cfg = m_bad;
      if (wr) m_thr = thr_high;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("rb0", rb0, m_thr);
      check("rb1", rb1, m_thr);
      check("cfg0", cfg0, m_cfg);
      check("cfg1", cfg1, m_cfg);
      check("alarm0", alarm0, m_alarm[0]);
      check("alarm1", alarm1, m_alarm[1]);
      check("ev0", ev0, m_ev[0]);
      check("ev1", ev1, m_ev[1]);
    end
  end

  task automatic cyc(input bit v, input logic [15:0] s, input bit c = 1'b0);
    @(negedge clk);
    valid = v; sample = s; wr = 1'b0; clr = c;
  endtask

  task automatic wr_hi(input logic [15:0] h);
    @(negedge clk);
    valid = 1'b0; wr = 1'b1; thr_high = h; clr = 1'b0;
  endtask

  logic [15:0] pat[5];
  logic [15:0] cur_hi;
  int mode, r;

  initial begin
    #2 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("reset_rb", rb0, 16'hFFFF);
    check("reset_alarm", alarm0, 0);
    check("reset_cfg", cfg0, 0);
    check("reset_ev", ev0, 0);

    // Alarm set and clear
    thr_low = 16'd100;
    wr_hi(16'd200);
    repeat (4) cyc(1, 16'd201);
    cyc(0, 0);
    check("set_alarm0", alarm0, 1);
    check("set_ev0", ev0, EV_EN ? 1 : 0);
    check("set_alarm1", alarm1, 1);
    repeat (4) cyc(1, 16'd99);
    cyc(0, 0);
    check("clear_alarm0", alarm0, 0);

    // Debounce break and equality
    pat = '{16'd201, 16'd201, 16'd201, 16'd150, 16'd201};
    for (int i = 0; i < 5; i++) cyc(1, pat[i]);
    cyc(0, 0);
    check("break_alarm0", alarm0, 0);
    cyc(1, 16'd150);
    repeat (6) cyc(1, 16'd200);
    cyc(0, 0);
    check("equal_alarm0", alarm0, 0);

    // Invalid gaps between qualifying samples
    for (int i = 0; i < 4; i++) begin
      cyc(1, 16'd201);
      repeat (i + 1) cyc(0, 0);
    end
    check("gap_alarm0", alarm0, 1);
    check("gap_ev0", ev0, EV_EN ? 2 : 0);

    // Config error and recovery
    cyc(0, 0);
    thr_low = 16'd300;
    cyc(0, 0);
    check("cfgerr_set", cfg0, 1);
    check("cfgerr_alarm0", alarm0, 0);
    wr_hi(16'd400);
    cyc(0, 0);
    cyc(0, 0);
    check("cfgerr_clr", cfg0, 0);
    repeat (3) cyc(1, 16'd401);
    cyc(0, 0);
    check("restart_pend", alarm0, 0);
    cyc(1, 16'd401);
    cyc(0, 0);
    check("restart_alarm", alarm0, 1);

    // Write/sample collision
    thr_low = 16'd10;
    repeat (4) cyc(1, 16'd5);
    wr_hi(16'd200);
    @(negedge clk);
    valid = 1'b1; sample = 16'd100; wr = 1'b1; thr_high = 16'd50; clr = 1'b0;
    cyc(0, 0);
    check("collide_old", alarm1, 0);
    cyc(1, 16'd100);
    cyc(0, 0);
    check("collide_new", alarm1, 1);

    // Counter saturation and clear priority
    cyc(0, 0, 1'b1);
    cyc(0, 0);
    check("clr_ev0", ev0, 0);
    for (int e = 0; e < 5; e++) begin
      repeat (4) cyc(1, 16'd60);
      repeat (4) cyc(1, 16'd5);
    end
    cyc(0, 0);
    check("sat_ev0", ev0, EV_EN ? 3 : 0);
    repeat (3) cyc(1, 16'd60);
    cyc(1, 16'd60, 1'b1);
    cyc(0, 0);
    check("clr_win_ev0", ev0, 0);
    check("clr_win_alarm0", alarm0, 1);

    // Randomised phase
    thr_low = 16'd100;
    cur_hi  = 16'd50;
    mode    = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 16 == 0) mode = int'($urandom_range(0, 3));
      r = int'($urandom_range(0, 99));
      @(negedge clk);
      valid = ($urandom_range(0, 3) != 0);
      case (mode)
        0: sample = 16'(cur_hi + $urandom_range(1, 20));
        1: sample = 16'(thr_low - $urandom_range(1, 20));
        2: sample = 16'($urandom_range(thr_low, cur_hi));
        default: sample = ($urandom_range(0, 1) != 0) ? thr_low : cur_hi;
      endcase
      wr  = (r < 2);
      clr = (r == 5);
      if (wr) begin
        cur_hi   = 16'($urandom_range(120, 300));
        thr_high = cur_hi;
      end
      if (r == 7) thr_low = 16'($urandom_range(50, 200));
    end

    // Reset mid-debounce discards the partial count
    thr_low = 16'd100;
    wr_hi(16'd200);
    repeat (4) cyc(1, 16'd99);
    cyc(1, 16'd201);
    cyc(1, 16'd201);
    cyc(0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_rb", rb0, 16'hFFFF);
    check("midrst_alarm", alarm0, 0);
    check("midrst_cfg", cfg0, 0);
    check("midrst_ev", ev0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wr_hi(16'd200);
    repeat (3) cyc(1, 16'd201);
    cyc(0, 0);
    check("postrst_partial", alarm0, 0);
    cyc(1, 16'd201);
    cyc(0, 0);
    check("postrst_alarm", alarm0, 1);

    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
